// File: rtl/alu_arbiter_if.sv
//------------------------------------------------------------------------------
// alu_arbiter_if : request/response and shared-ALU signals of alu_arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [1:0] req0_sel;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [1:0] req1_sel;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [3:0] rsp0_c;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [3:0] rsp1_c;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_c;
  logic       busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready, alu_c,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_c, rsp1_valid, rsp1_c,
    output alu_a, alu_b, alu_sel, busy
  );

  // Client / ALU side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready, alu_c,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_c, rsp1_valid, rsp1_c,
    input  alu_a, alu_b, alu_sel, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one registered 4-bit ALU by two clients
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [3:0] result_q, result_d;
  logic       grant0;
  logic       grant1;
  logic       rsp_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_sel_q <= 2'd0;
      result_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        // prio only breaks ties; a lone requester always wins
        grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
        if (grant0) begin
          alu_a_d   = bus.req0_a;
          alu_b_d   = bus.req0_b;
          alu_sel_d = bus.req0_sel;
          owner_d   = 1'b0;
          state_d   = EXEC;
        end else if (grant1) begin
          alu_a_d   = bus.req1_a;
          alu_b_d   = bus.req1_b;
          alu_sel_d = bus.req1_sel;
          owner_d   = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_c;
        state_d  = RESP;
      end
      RESP: begin
        rsp_hs = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_hs) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp0_c     = result_q;
  assign bus.rsp1_c     = result_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// tb_alu_arbiter : directed vector bench for alu_arbiter with a model of the ALU
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;
  int   cyc;
  int   last_acc;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The shared ALU sitting between the operand and result registers
  always_comb begin
    case (bus.alu_sel)
      2'b00:   bus.alu_c = bus.alu_a & bus.alu_b;
      2'b01:   bus.alu_c = bus.alu_a | bus.alu_b;
      2'b10:   bus.alu_c = bus.alu_a + bus.alu_b;
      default: bus.alu_c = bus.alu_a - bus.alu_b;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         client;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit c, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] sel);
    if (c) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end
  endtask

  // Lone request: accept, EXEC, RESP with immediate rsp_ready. Starts and ends posedge+1 in IDLE.
  task automatic do_op(input bit c, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel, input logic [3:0] exp, input bit chk_gap);
    drive_req(c, 1'b1, a, b, sel);
    @(negedge clk);
    chk("idle_ready_winner", c ? bus.req1_ready : bus.req0_ready, 1);
    chk("idle_ready_other",  c ? bus.req0_ready : bus.req1_ready, 0);
    chk("idle_busy", bus.busy, 0);
    step();
    if (chk_gap) chk("issue_interval", cyc - last_acc, 3);
    last_acc = cyc;
    drive_req(c, 1'b0, a, b, sel);
    @(negedge clk);
    chk("exec_busy", bus.busy, 1);
    chk("exec_alu_a", bus.alu_a, a);
    chk("exec_alu_b", bus.alu_b, b);
    chk("exec_alu_sel", bus.alu_sel, sel);
    chk("exec_rsp_valid", bus.rsp0_valid | bus.rsp1_valid, 0);
    step();
    @(negedge clk);
    chk("resp_valid", c ? bus.rsp1_valid : bus.rsp0_valid, 1);
    chk("resp_other_valid", c ? bus.rsp0_valid : bus.rsp1_valid, 0);
    chk("resp_c", c ? bus.rsp1_c : bus.rsp0_c, exp);
    step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [3:0] held_c;

  initial begin
    ncmp = 0; nerr = 0; cyc = 0; last_acc = 0;
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sel = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sel = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;

    vecs[0] = '{1'b0, 4'd6,  4'd3,  2'b10, 4'd9};
    vecs[1] = '{1'b0, 4'd12, 4'd10, 2'b00, 4'd8};
    vecs[2] = '{1'b1, 4'd12, 4'd10, 2'b01, 4'd14};
    vecs[3] = '{1'b0, 4'd15, 4'd1,  2'b10, 4'd0};
    vecs[4] = '{1'b1, 4'd0,  4'd1,  2'b11, 4'd15};
    vecs[5] = '{1'b0, 4'd3,  4'd5,  2'b11, 4'd14};
    vecs[6] = '{1'b1, 4'd9,  4'd5,  2'b11, 4'd4};
    vecs[7] = '{1'b1, 4'd5,  4'd10, 2'b01, 4'd15};
    vecs[8] = '{1'b1, 4'd7,  4'd8,  2'b00, 4'd0};
    vecs[9] = '{1'b0, 4'd9,  4'd9,  2'b10, 4'd2};

    // Reset state
    step();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_req_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    chk("rst_result", bus.rsp0_c, 0);
    step();
    rst_n = 1'b1;
    step();

    // Lone-requester vectors, issued back-to-back at the minimum interval
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, i > 0);

    // Both valid: prio after reset favours client 0, then alternates
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      drive_req(1'b0, 1'b1, 4'd12, 4'd10, 2'b00);
      drive_req(1'b1, 1'b1, 4'd12, 4'd10, 2'b01);
      @(negedge clk);
      chk("both_ready0", bus.req0_ready, 1);
      chk("both_ready1", bus.req1_ready, 0);
      step();
      drive_req(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
      step();
      @(negedge clk);
      chk("both_rsp0_valid", bus.rsp0_valid, 1);
      chk("both_rsp0_c", bus.rsp0_c, 8);
      chk("both_wait_ready1", bus.req1_ready, 0);
      step();
      @(negedge clk);
      chk("both_ready1_turn", bus.req1_ready, 1);
      step();
      drive_req(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
      step();
      @(negedge clk);
      chk("both_rsp1_valid", bus.rsp1_valid, 1);
      chk("both_rsp1_c", bus.rsp1_c, 14);
      step();
    end

    // Backpressure on rsp1 while req0 waits
    do_op(1'b1, 4'd2, 4'd3, 2'b10, 4'd5, 1'b0);
    bus.rsp1_ready = 1'b0;
    drive_req(1'b1, 1'b1, 4'd9, 4'd4, 2'b11);
    step();
    drive_req(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    drive_req(1'b0, 1'b1, 4'd4, 4'd4, 2'b10);
    step();
    held_c = 4'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", bus.rsp1_valid, 1);
      chk("bp_rsp1_c", bus.rsp1_c, held_c);
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_busy", bus.busy, 1);
      step();
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_req0_ready_before_hs", bus.req0_ready, 0);
    step();
    @(negedge clk);
    chk("bp_req0_ready_after_hs", bus.req0_ready, 1);
    step();
    drive_req(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    step();
    @(negedge clk);
    chk("bp_rsp0_c", bus.rsp0_c, 8);
    chk("bp_rsp0_valid", bus.rsp0_valid, 1);
    step();

    // Reset during EXEC drops the transaction
    drive_req(1'b0, 1'b1, 4'd6, 4'd3, 2'b10);
    step();
    drive_req(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    chk("mid_rst_alu_b", bus.alu_b, 0);
    chk("mid_rst_alu_sel", bus.alu_sel, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
      chk("post_rst_busy", bus.busy, 0);
      step();
    end
    do_op(1'b0, 4'd6, 4'd3, 2'b10, 4'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", ncmp);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
